// File: rtl/spi_cmd_queue_if.sv
// Bundles the spi_cmd_queue request, status and SPI transmitter signals.
// master: producer side (control logic plus the transmitter's done flag).
// slave:  the queue itself.
// Signals: wr_en/wr_dc/wr_data push a byte, flush drops queued bytes,
// cfg_prescaler sets the SCL prescaler, spi_done is the transmitter
// completion flag, spi_control/spi_data drive the transmitter, and
// full/empty/count/busy/overflow report queue status.
interface spi_cmd_queue_if #(
  parameter int unsigned ADDR_W = 4
);
  logic            wr_en;
  logic            wr_dc;
  logic [7:0]      wr_data;
  logic            flush;
  logic [7:0]      cfg_prescaler;
  logic            spi_done;
  logic [9:0]      spi_control;
  logic [7:0]      spi_data;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            busy;
  logic            overflow;

  modport master (
    output wr_en, wr_dc, wr_data, flush, cfg_prescaler, spi_done,
    input  spi_control, spi_data, full, empty, count, busy, overflow
  );

  modport slave (
    input  wr_en, wr_dc, wr_data, flush, cfg_prescaler, spi_done,
    output spi_control, spi_data, full, empty, count, busy, overflow
  );
endinterface

// File: rtl/spi_cmd_queue.sv
// Command/data byte queue feeding the SPI transmit block.
// Buffers {dc, data} entries in a FIFO and hands them to the transmitter one at
// a time: load the byte and fields, raise enable, wait for a rising spi_done,
// drop enable and hold it low for GAP_CYCLES before the next byte.
// Ports: clk, reset (async, active-high), bus (spi_cmd_queue_if.slave) carrying
// the push/flush requests, the transmitter control word/byte/done and status.
module spi_cmd_queue #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  spi_cmd_queue_if.slave  bus
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0]   GapLast   = GapW'(GAP_CYCLES - 1);
  localparam logic [GapW-1:0]   GapOne    = GapW'(1);
  localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StGap} state_e;

  state_e            state_q, state_d;
  logic [8:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic [7:0]        data_q;
  logic              dc_q;
  logic [7:0]        presc_q;
  logic              enable_q, enable_d;
  logic              done_prev_q, done_prev_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              load;

  logic full, empty, pop, push, ovf_set;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  // The head is consumed in the LOAD cycle; a full queue can still take a push then.
  assign pop     = (state_q == StLoad) && !empty;
  assign push    = bus.wr_en && (!full || pop);
  assign ovf_set = bus.wr_en && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop)      count_q <= count_q + CountOne;
      else if (pop && !push) count_q <= count_q - CountOne;
      if (ovf_set) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem_q[wr_ptr_q] <= {bus.wr_dc, bus.wr_data};
  end

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    done_prev_d = done_prev_q;
    load        = 1'b0;
    unique case (state_q)
      // A same-cycle flush empties the queue, so do not start another byte.
      StIdle: if (!empty && !bus.flush) state_d = StLoad;
      StLoad: begin
        load    = 1'b1;
        state_d = StStart;
      end
      StStart: begin
        done_prev_d = bus.spi_done;
        state_d     = StWait;
      end
      StWait: begin
        done_prev_d = bus.spi_done;
        // Only a 0->1 transition completes; a done already high must fall first.
        if (bus.spi_done && !done_prev_q) begin
          state_d   = StGap;
          gap_cnt_d = '0;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = (!empty && !bus.flush) ? StLoad : StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapOne;
        end
      end
      default: state_d = StIdle;
    endcase
    enable_d = (state_d == StStart) || (state_d == StWait);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      gap_cnt_q   <= '0;
      done_prev_q <= 1'b0;
      enable_q    <= 1'b0;
      data_q      <= '0;
      dc_q        <= 1'b0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      done_prev_q <= done_prev_d;
      enable_q    <= enable_d;
      if (load) begin
        data_q  <= mem_q[rd_ptr_q][7:0];
        dc_q    <= mem_q[rd_ptr_q][8];
        presc_q <= bus.cfg_prescaler;
      end
    end
  end

  assign bus.spi_control = {presc_q, dc_q, enable_q};
  assign bus.spi_data    = data_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_spi_cmd_queue.sv
module tb_spi_cmd_queue;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int GAP = 2;

  // Model transfer phases
  localparam int MIdle = 0, MLoad = 1, MStart = 2, MWait = 3, MGap = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  spi_cmd_queue_if #(.ADDR_W(ADDR_W)) bus ();

  spi_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: queue of {dc, data} plus the transfer in progress.
  logic [8:0] mq[$];
  int         m_mode = MIdle;
  int         m_gap_left = 0;
  logic       m_en = 1'b0, m_dc = 1'b0, m_prev = 1'b0, m_ovf = 1'b0;
  logic [7:0] m_data = 8'h00, m_presc = 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_mode = MIdle; m_gap_left = 0;
      m_en = 1'b0; m_dc = 1'b0; m_prev = 1'b0; m_ovf = 1'b0;
      m_data = 8'h00; m_presc = 8'h00;
    end else begin
      int   n;
      bit   popped;
      logic [8:0] head;
      n = mq.size();
      popped = (m_mode == MLoad) && (n > 0);
      case (m_mode)
        MIdle: if (n > 0 && !bus.flush) m_mode = MLoad;
        MLoad: begin
          head = mq[0];
          m_dc = head[8]; m_data = head[7:0]; m_presc = bus.cfg_prescaler;
          m_en = 1'b1; m_mode = MStart;
        end
        MStart: begin m_prev = bus.spi_done; m_mode = MWait; end
        MWait: begin
          if (bus.spi_done && !m_prev) begin
            m_en = 1'b0; m_mode = MGap; m_gap_left = GAP;
          end
          m_prev = bus.spi_done;
        end
        default: begin
          m_gap_left--;
          if (m_gap_left == 0) m_mode = (n > 0 && !bus.flush) ? MLoad : MIdle;
        end
      endcase
      if (popped) void'(mq.pop_front());
      if (bus.flush) begin
        mq.delete();
        m_ovf = 1'b0;
      end else if (bus.wr_en) begin
        if (n < DEPTH || popped) mq.push_back({bus.wr_dc, bus.wr_data});
        else m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      logic [9:0] ectl;
      logic [4:0] ecnt;
      ectl = {m_presc, m_dc, m_en};
      ecnt = 5'(mq.size());
      checks++;
      if (bus.spi_control !== ectl || bus.spi_data !== m_data || bus.count !== ecnt ||
          bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0) ||
          bus.busy !== (m_mode != MIdle) || bus.overflow !== m_ovf) begin
        errors++;
        $display("FAIL model t=%0t ctl=%h/%h data=%h/%h cnt=%0d/%0d busy=%b/%b ovf=%b/%b",
                 $time, bus.spi_control, ectl, bus.spi_data, m_data, bus.count, ecnt,
                 bus.busy, (m_mode != MIdle), bus.overflow, m_ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push_byte(input logic dc, input logic [7:0] data);
    bus.wr_en = 1'b1; bus.wr_dc = dc; bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Wait (bounded) for enable, check the byte, then complete it with a done pulse.
  task automatic serve(input logic exp_dc, input logic [7:0] exp_data, input bit chk_gap);
    int lows = 1;
    int t = 0;
    while (!bus.spi_control[0] && t < 50) begin
      tick(); t++;
      if (!bus.spi_control[0]) lows++;
    end
    chk("serve_en", 32'(bus.spi_control[0]), 32'd1);
    chk("serve_dc", 32'(bus.spi_control[1]), 32'(exp_dc));
    chk("serve_data", 32'(bus.spi_data), 32'(exp_data));
    if (chk_gap) chk("serve_gap_low", 32'(lows >= 2), 32'd1);
    repeat (3) tick();
    bus.spi_done = 1'b1;
    tick();
    bus.spi_done = 1'b0;
    chk("serve_fall", 32'(bus.spi_control[0]), 32'd0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_dc = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0;
    bus.cfg_prescaler = 8'h04; bus.spi_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_ctl", 32'(bus.spi_control), 32'h0);
    chk("rst_data", 32'(bus.spi_data), 32'h0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    tick();

    // Single command byte
    push_byte(1'b0, 8'hAE);
    chk("t1_cnt1", 32'(bus.count), 32'd1);
    chk("t1_en_lo", 32'(bus.spi_control), 32'h000);
    tick();
    chk("t1_load_lo", 32'(bus.spi_control[0]), 32'd0);
    tick();
    chk("t1_ctl", 32'(bus.spi_control), 32'h011);
    chk("t1_data", 32'(bus.spi_data), 32'hAE);
    repeat (20) tick();
    chk("t1_hold", 32'(bus.spi_control), 32'h011);
    bus.spi_done = 1'b1;
    tick();
    bus.spi_done = 1'b0;
    chk("t1_fall", 32'(bus.spi_control), 32'h010);
    chk("t1_busy_gap", 32'(bus.busy), 32'd1);
    tick();
    chk("t1_busy_gap2", 32'(bus.busy), 32'd1);
    tick();
    chk("t1_idle", 32'(bus.busy), 32'd0);

    // Three back-to-back entries
    push_byte(1'b0, 8'h21);
    push_byte(1'b1, 8'h55);
    push_byte(1'b1, 8'hAA);
    serve(1'b0, 8'h21, 1'b0);
    serve(1'b1, 8'h55, 1'b1);
    serve(1'b1, 8'hAA, 1'b1);
    repeat (5) tick();
    chk("t2_idle", 32'(bus.busy), 32'd0);

    // Fill to full, push during LOAD, then overflow
    for (int i = 0; i < 17; i++) push_byte(1'b1, 8'(i));
    chk("t3_count", 32'(bus.count), 32'd16);
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_ovf0", 32'(bus.overflow), 32'd0);
    bus.spi_done = 1'b1;
    tick();
    bus.spi_done = 1'b0;
    repeat (2) tick();
    push_byte(1'b0, 8'hC3);
    chk("t4_count", 32'(bus.count), 32'd16);
    chk("t4_ovf0", 32'(bus.overflow), 32'd0);
    push_byte(1'b0, 8'hC4);
    chk("t3_ovf1", 32'(bus.overflow), 32'd1);
    chk("t3_count_hold", 32'(bus.count), 32'd16);

    // Flush during WAIT with 5 queued
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(1'b1, 8'(8'h60 + i));
    chk("t5_pre", 32'(bus.count), 32'd5);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_empty", 32'(bus.empty), 32'd1);
    chk("t5_ovf", 32'(bus.overflow), 32'd0);
    chk("t5_inflight", 32'(bus.spi_control[0]), 32'd1);
    bus.spi_done = 1'b1; tick(); bus.spi_done = 1'b0;
    repeat (12) tick();
    chk("t5_idle", 32'(bus.busy), 32'd0);
    chk("t5_no_en", 32'(bus.spi_control[0]), 32'd0);

    // Reset during WAIT
    push_byte(1'b1, 8'h3C);
    push_byte(1'b0, 8'h3D);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("t6_ctl", 32'(bus.spi_control), 32'h0);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    push_byte(1'b1, 8'h99);
    tick();
    chk("t6_lat_lo", 32'(bus.spi_control[0]), 32'd0);
    tick();
    chk("t6_lat_hi", 32'(bus.spi_control), 32'h013);
    chk("t6_data", 32'(bus.spi_data), 32'h99);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int rate;
      rate = ((i / 400) % 2 == 1) ? 1 : 4;
      bus.wr_en = ($urandom_range(0, rate) == 0);
      bus.wr_dc = 1'($urandom);
      bus.wr_data = 8'($urandom);
      bus.flush = ($urandom_range(0, 150) == 0);
      bus.cfg_prescaler = 8'($urandom);
      if ($urandom_range(0, 5) == 0) bus.spi_done = ~bus.spi_done;
      if ($urandom_range(0, 1500) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    bus.wr_en = 1'b0; bus.flush = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
